// File: rtl/fsk_bit_decoder.sv
// FSK bit decoder: hysteresis slicer on the measured tone frequency followed by an 8N1 UART receiver.
// Define FSK_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module fsk_bit_decoder #(
  parameter int unsigned CLOCK_FREQ = 200000000,
  parameter int unsigned BAUD       = 1200,
  parameter int unsigned MARK_FREQ  = 1200,
  parameter int unsigned SPACE_FREQ = 2200,
  parameter int unsigned HYST       = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frequency,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        framing_error,
  output logic        parity_error,
  output logic        busy,
  output logic        bit_level
);

  localparam int unsigned BIT_PERIOD = CLOCK_FREQ / BAUD;
  localparam int unsigned CNT_W      = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [31:0] THRESHOLD  = (MARK_FREQ + SPACE_FREQ) / 2;
  localparam logic [31:0] THRESH_HI  = THRESHOLD + HYST;
  localparam logic [31:0] THRESH_LO  = THRESHOLD - HYST;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateType;

  stateType         stateReg, stateNext;
  logic [CNT_W-1:0] baudCntReg, baudCntNext;
  logic [2:0]       bitIdxReg, bitIdxNext;
  logic [7:0]       shiftReg, shiftNext;
  logic [7:0]       dataOutNext;
  logic             dataValidNext, framingErrNext, busyNext;
  logic             levelNext, levelD;
  logic             startEdge, sampleEvt;

  // A zero reading means the upstream stage has no measurement yet, so the level is held.
  always_comb begin
    levelNext = bit_level;
    if (frequency != '0) begin
      if (frequency > THRESH_HI)
        levelNext = 1'b0;
      else if (frequency < THRESH_LO)
        levelNext = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_level <= 1'b1;
      levelD    <= 1'b1;
    end else begin
      bit_level <= levelNext;
      levelD    <= bit_level;
    end
  end

  assign startEdge = levelD & ~bit_level;
  assign sampleEvt = (baudCntReg == '0);

`ifdef FSK_PARITY_EN
  logic parityBitReg, parityBitNext, parityErrNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parityBitReg <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parityBitReg <= parityBitNext;
      parity_error <= parityErrNext;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  always_comb begin
    stateNext      = stateReg;
    baudCntNext    = (baudCntReg != '0) ? baudCntReg - 1'b1 : baudCntReg;
    bitIdxNext     = bitIdxReg;
    shiftNext      = shiftReg;
    dataOutNext    = data_out;
    dataValidNext  = 1'b0;
    framingErrNext = 1'b0;
`ifdef FSK_PARITY_EN
    parityBitNext  = parityBitReg;
    parityErrNext  = 1'b0;
`endif
    case (stateReg)
      IDLE: begin
        if (startEdge) begin
          baudCntNext = HALF_LOAD;
          stateNext   = START;
        end
      end
      START: begin
        // The start bit must still read space at mid-bit, otherwise the edge was a glitch.
        if (sampleEvt) begin
          if (!bit_level) begin
            baudCntNext = FULL_LOAD;
            bitIdxNext  = '0;
            stateNext   = DATA;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      DATA: begin
        if (sampleEvt) begin
          shiftNext   = {bit_level, shiftReg[7:1]};
          bitIdxNext  = bitIdxReg + 1'b1;
          baudCntNext = FULL_LOAD;
          if (bitIdxReg == 3'd7) begin
`ifdef FSK_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef FSK_PARITY_EN
      PARITY: begin
        if (sampleEvt) begin
          parityBitNext = bit_level;
          baudCntNext   = FULL_LOAD;
          stateNext     = STOP;
        end
      end
`endif
      STOP: begin
        if (sampleEvt) begin
          stateNext = IDLE;
          if (!bit_level) begin
            framingErrNext = 1'b1;
`ifdef FSK_PARITY_EN
          end else if (^{shiftReg, parityBitReg}) begin
            parityErrNext = 1'b1;
`endif
          end else begin
            dataOutNext   = shiftReg;
            dataValidNext = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busyNext = (stateNext != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg      <= IDLE;
      baudCntReg    <= '0;
      bitIdxReg     <= '0;
      shiftReg      <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      baudCntReg    <= baudCntNext;
      bitIdxReg     <= bitIdxNext;
      shiftReg      <= shiftNext;
      data_out      <= dataOutNext;
      data_valid    <= dataValidNext;
      framing_error <= framingErrNext;
      busy          <= busyNext;
    end
  end

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// Directed testbench for fsk_bit_decoder at BIT_PERIOD = 100 cycles (120 kHz clock, 1200 baud).
// Follows FSK_PARITY_EN so the frame shape matches the design build.
module tb_fsk_bit_decoder;
  localparam int BP = 100;
  localparam logic [31:0] MARK  = 32'd1200;
  localparam logic [31:0] SPACE = 32'd2200;
`ifdef FSK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Stop-bit result appears 952 ticks after space is first driven (slicer + edge + 9.5 bits + register).
  localparam int EXP_TICK = 952 + PAR_BITS * BP;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] frequency;
  logic [7:0]  data_out;
  logic        data_valid, framing_error, parity_error, busy, bit_level;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc, dvCnt, feCnt, peCnt, firstPulseCyc, overlapCnt;

  fsk_bit_decoder #(
    .CLOCK_FREQ(120000), .BAUD(1200), .MARK_FREQ(1200), .SPACE_FREQ(2200), .HYST(100)
  ) dut (
    .clk(clk), .rst(rst), .frequency(frequency), .data_out(data_out),
    .data_valid(data_valid), .framing_error(framing_error), .parity_error(parity_error),
    .busy(busy), .bit_level(bit_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int n;
    @(posedge clk);
    #1;
    cyc++;
    n = 0;
    if (data_valid === 1'b1) begin dvCnt++; n++; end
    if (framing_error === 1'b1) begin feCnt++; n++; end
    if (parity_error === 1'b1) begin peCnt++; n++; end
    if (n > 0 && firstPulseCyc < 0) firstPulseCyc = cyc;
    if (n > 1) overlapCnt++;
  endtask

  task automatic clear_mon();
    cyc = 0; dvCnt = 0; feCnt = 0; peCnt = 0; firstPulseCyc = -1; overlapCnt = 0;
  endtask

  task automatic hold(input logic [31:0] f, input int n);
    frequency = f;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic parBit, input logic stopLvl);
    hold(SPACE, BP);
    for (int i = 0; i < 8; i++) hold(b[i] ? MARK : SPACE, BP);
`ifdef FSK_PARITY_EN
    hold(parBit ? MARK : SPACE, BP);
`else
    if (parBit === 1'bx) $display("note: parity bit unused");
`endif
    hold(stopLvl ? MARK : SPACE, BP);
  endtask

  task automatic report(input logic [7:0] b);
    $display("frame 0x%02h: valid=%0d ferr=%0d perr=%0d data_out=0x%02h first_pulse=%0d",
             b, dvCnt, feCnt, peCnt, data_out, firstPulseCyc);
  endtask

  task automatic test_reset();
    rst = 1'b1; frequency = 32'd0;
    clear_mon();
    for (int i = 0; i < 3; i++) tick();
    totalCnt++; if (bit_level !== 1'b1) $display("FAIL reset_bit_level: got %b expected 1", bit_level); else passCnt++;
    totalCnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", data_out); else passCnt++;
    rst = 1'b0;
    hold(32'd0, 1000);
    totalCnt++; if (bit_level !== 1'b1) $display("FAIL idle_bit_level: got %b expected 1", bit_level); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passCnt++;
    totalCnt++; if (data_out !== 8'h00) $display("FAIL idle_data_out: got %h expected 00", data_out); else passCnt++;
    totalCnt++; if (dvCnt + feCnt + peCnt !== 0) $display("FAIL idle_pulses: got %0d expected 0", dvCnt + feCnt + peCnt); else passCnt++;
    hold(MARK, 50);
  endtask

  task automatic test_frame_a5();
    clear_mon();
    send_frame(8'hA5, ^8'hA5, 1'b1);
    hold(MARK, 50);
    report(8'hA5);
    totalCnt++; if (dvCnt !== 1) $display("FAIL a5_valid_count: got %0d expected 1", dvCnt); else passCnt++;
    totalCnt++; if (firstPulseCyc < EXP_TICK - 2 || firstPulseCyc > EXP_TICK + 2)
      $display("FAIL a5_valid_time: got %0d expected %0d+-2", firstPulseCyc, EXP_TICK); else passCnt++;
    totalCnt++; if (data_out !== 8'hA5) $display("FAIL a5_data_out: got %h expected a5", data_out); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL a5_busy_after: got %b expected 0", busy); else passCnt++;
    totalCnt++; if (feCnt + peCnt !== 0) $display("FAIL a5_err_pulses: got %0d expected 0", feCnt + peCnt); else passCnt++;
  endtask

  task automatic test_glitch();
    clear_mon();
    hold(SPACE, 30);
    hold(MARK, 15);
    totalCnt++; if (busy !== 1'b1) $display("FAIL glitch_busy_mid: got %b expected 1", busy); else passCnt++;
    hold(MARK, 10);
    totalCnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", busy); else passCnt++;
    hold(MARK, 200);
    $display("glitch: valid=%0d ferr=%0d perr=%0d busy=%b", dvCnt, feCnt, peCnt, busy);
    totalCnt++; if (dvCnt + feCnt + peCnt !== 0) $display("FAIL glitch_pulses: got %0d expected 0", dvCnt + feCnt + peCnt); else passCnt++;
  endtask

  task automatic test_hysteresis();
    clear_mon();
    hold(32'd1750, 20);
    totalCnt++; if (bit_level !== 1'b1) $display("FAIL hyst_1750: got %b expected 1", bit_level); else passCnt++;
    hold(32'd1801, 1);
    totalCnt++; if (bit_level !== 1'b0) $display("FAIL hyst_1801: got %b expected 0", bit_level); else passCnt++;
    hold(32'd1801, 9);
    hold(32'd0, 10);
    totalCnt++; if (bit_level !== 1'b0) $display("FAIL hyst_zero_hold: got %b expected 0", bit_level); else passCnt++;
    hold(32'd1650, 15);
    totalCnt++; if (bit_level !== 1'b0) $display("FAIL hyst_1650: got %b expected 0", bit_level); else passCnt++;
    hold(32'd1599, 1);
    totalCnt++; if (bit_level !== 1'b1) $display("FAIL hyst_1599: got %b expected 1", bit_level); else passCnt++;
    hold(MARK, 200);
    $display("hysteresis: valid=%0d ferr=%0d busy=%b", dvCnt, feCnt, busy);
    totalCnt++; if (dvCnt + feCnt + peCnt !== 0) $display("FAIL hyst_pulses: got %0d expected 0", dvCnt + feCnt + peCnt); else passCnt++;
  endtask

  task automatic test_framing_error();
    clear_mon();
    send_frame(8'h3C, ^8'h3C, 1'b0);
    hold(MARK, 300);
    report(8'h3C);
    totalCnt++; if (feCnt !== 1) $display("FAIL ferr_count: got %0d expected 1", feCnt); else passCnt++;
    totalCnt++; if (firstPulseCyc < EXP_TICK - 2 || firstPulseCyc > EXP_TICK + 2)
      $display("FAIL ferr_time: got %0d expected %0d+-2", firstPulseCyc, EXP_TICK); else passCnt++;
    totalCnt++; if (dvCnt + peCnt !== 0) $display("FAIL ferr_other_pulses: got %0d expected 0", dvCnt + peCnt); else passCnt++;
    totalCnt++; if (data_out !== 8'hA5) $display("FAIL ferr_data_out: got %h expected a5", data_out); else passCnt++;
    totalCnt++; if (busy !== 1'b0) $display("FAIL ferr_busy: got %b expected 0", busy); else passCnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h3C;
    clear_mon();
    hold(SPACE, BP);
    for (int i = 0; i < 4; i++) hold(b[i] ? MARK : SPACE, BP);
    hold(b[4] ? MARK : SPACE, 50);
    totalCnt++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", busy); else passCnt++;
    rst = 1'b1;
    #1;
    totalCnt++; if (busy !== 1'b0 || data_out !== 8'h00 || bit_level !== 1'b1)
      $display("FAIL rstmid_async: got busy=%b data_out=%h bit_level=%b expected 0 00 1", busy, data_out, bit_level); else passCnt++;
    hold(SPACE, 3);
    totalCnt++; if (busy !== 1'b0 || data_out !== 8'h00 || bit_level !== 1'b1 || data_valid !== 1'b0 || framing_error !== 1'b0 || parity_error !== 1'b0)
      $display("FAIL rstmid_held: got busy=%b data_out=%h bit_level=%b dv=%b fe=%b pe=%b expected 0 00 1 0 0 0",
               busy, data_out, bit_level, data_valid, framing_error, parity_error); else passCnt++;
    frequency = MARK;
    rst = 1'b0;
    hold(MARK, 200);
    totalCnt++; if (dvCnt + feCnt + peCnt !== 0 || busy !== 1'b0)
      $display("FAIL rstmid_quiet: got pulses=%0d busy=%b expected 0 0", dvCnt + feCnt + peCnt, busy); else passCnt++;
    clear_mon();
    send_frame(b, ^b, 1'b1);
    hold(MARK, 50);
    report(b);
    totalCnt++; if (dvCnt !== 1) $display("FAIL rstmid_valid_count: got %0d expected 1", dvCnt); else passCnt++;
    totalCnt++; if (data_out !== 8'h3C) $display("FAIL rstmid_data_out: got %h expected 3c", data_out); else passCnt++;
  endtask

  task automatic test_parity();
    clear_mon();
    send_frame(8'h3C, ~(^8'h3C), 1'b1);
    hold(MARK, 50);
    report(8'h3C);
`ifdef FSK_PARITY_EN
    totalCnt++; if (peCnt !== 1) $display("FAIL parity_err_count: got %0d expected 1", peCnt); else passCnt++;
    totalCnt++; if (dvCnt !== 0) $display("FAIL parity_valid_count: got %0d expected 0", dvCnt); else passCnt++;
    totalCnt++; if (data_out !== 8'h3C) $display("FAIL parity_data_out: got %h expected 3c", data_out); else passCnt++;
`else
    totalCnt++; if (peCnt !== 0) $display("FAIL parity_tied: got %0d expected 0", peCnt); else passCnt++;
`endif
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'h55, ^8'h55, 1'b1);
    totalCnt++; if (data_out !== 8'h55) $display("FAIL b2b_first_data: got %h expected 55", data_out); else passCnt++;
    send_frame(8'h0F, ^8'h0F, 1'b1);
    hold(MARK, 50);
    report(8'h0F);
    totalCnt++; if (dvCnt !== 2) $display("FAIL b2b_valid_count: got %0d expected 2", dvCnt); else passCnt++;
    totalCnt++; if (data_out !== 8'h0F) $display("FAIL b2b_data_out: got %h expected 0f", data_out); else passCnt++;
    totalCnt++; if (overlapCnt !== 0) $display("FAIL b2b_overlap: got %0d expected 0", overlapCnt); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_hysteresis();
    test_framing_error();
    test_reset_mid_frame();
    test_parity();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
